// File: rtl/scale_shift.sv
// Scales a frame of DW-bit signed words down to OW bits: a right-shift amount is derived
// from the frame maximum, then each word is rounded (half up) and saturated on its way out.
module scale_shift #(
    parameter int AW        = 12,
    parameter int DW        = 32,
    parameter int OW        = 8,
    parameter int DATA_SIZE = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          upstream_done,
    input  logic [DW-1:0] scale,
    output logic          scale_shift_ready,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] data_in,
    output logic [OW-1:0] wr_data,
    output logic [AW-1:0] wr_addr,
    output logic          wr_ena,
    input  logic          downstream_ready,
    output logic          scale_shift_done,
    output logic [2:0]    dbg_state
);

    localparam int SW = $clog2(DW);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DATA_SIZE - 1);
    localparam logic signed [DW:0] SAT_HI = {{(DW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [DW:0] SAT_LO = {{(DW-OW+2){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CALC    = 3'd1,
        S_RUN     = 3'd2,
        S_DRAIN   = 3'd3,
        S_WAIT_DS = 3'd4
    } state_t;

    state_t            r_state;
    logic [DW-1:0]     r_scale;
    logic [SW-1:0]     r_shift;
    logic [AW-1:0]     r_rd_addr;
    logic              r_iss_v;
    logic              r_v1;
    logic              r_v2;
    logic [AW-1:0]     r_a1;
    logic [AW-1:0]     r_a2;
    logic [OW-1:0]     r_wr_data;
    logic [AW-1:0]     r_wr_addr;
    logic              r_wr_ena;
    logic              r_ready;
    logic              r_done;

    logic [SW-1:0]     w_msb;
    logic [SW-1:0]     w_shift;
    logic signed [DW:0] w_ext;
    logic signed [DW:0] w_rnd;
    logic signed [DW:0] w_sum;
    logic signed [DW:0] w_y;
    logic [OW-1:0]     w_sat;

    // Position of the leading one of the latched maximum; zero scale maps to position 0.
    always_comb begin
        w_msb = '0;
        for (int i = 0; i < DW; i++) begin
            if (r_scale[i]) w_msb = SW'(i);
        end
        if (w_msb > SW'(OW - 2)) w_shift = w_msb - SW'(OW - 2);
        else                     w_shift = '0;
    end

    // One extra bit of headroom keeps the rounding add from overflowing.
    always_comb begin
        w_ext = {data_in[DW-1], data_in};
        if (r_shift == '0) w_rnd = '0;
        else               w_rnd = (DW+1)'(1) << (r_shift - 1'b1);
        w_sum = w_ext + w_rnd;
        w_y   = w_sum >>> r_shift;
        if (w_y > SAT_HI)      w_sat = SAT_HI[OW-1:0];
        else if (w_y < SAT_LO) w_sat = SAT_LO[OW-1:0];
        else                   w_sat = w_y[OW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_scale   <= '0;
            r_shift   <= '0;
            r_rd_addr <= '0;
            r_iss_v   <= 1'b0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_a1      <= '0;
            r_a2      <= '0;
            r_wr_data <= '0;
            r_wr_addr <= '0;
            r_wr_ena  <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            // Read-issue flag and address follow the 2-cycle memory latency.
            r_v1     <= r_iss_v;
            r_a1     <= r_rd_addr;
            r_v2     <= r_v1;
            r_a2     <= r_a1;
            r_wr_ena <= r_v2;
            if (r_v2) begin
                r_wr_data <= w_sat;
                r_wr_addr <= r_a2;
            end

            case (r_state)
                S_IDLE: begin
                    // The done cycle itself is not an acceptance slot.
                    if (upstream_done && !r_done) begin
                        r_scale <= scale;
                        r_ready <= 1'b0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_shift   <= w_shift;
                    r_rd_addr <= '0;
                    r_iss_v   <= 1'b1;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    if (r_rd_addr == LAST_ADDR) begin
                        r_iss_v <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_v2 && (r_a2 == LAST_ADDR)) r_state <= S_WAIT_DS;
                end
                S_WAIT_DS: begin
                    if (downstream_ready) begin
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign scale_shift_ready = r_ready;
    assign rd_addr           = r_rd_addr;
    assign wr_data           = r_wr_data;
    assign wr_addr           = r_wr_addr;
    assign wr_ena            = r_wr_ena;
    assign scale_shift_done  = r_done;
    assign dbg_state         = r_state;

endmodule
